// File: rtl/seq_detect_ctrl.sv
// Programmable bit-serial pattern detector with arm/disarm control,
// saturating overlapping-match counter and sticky threshold interrupt.
module seq_detect_ctrl #(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = 4'b1011
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [PAT_W-1:0]       cfg_pattern_i,
    input  logic [$clog2(PAT_W):0] cfg_len_i,
    input  logic [CNT_W-1:0]       cfg_thresh_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   in_valid_i,
    input  logic                   in_i,
    output logic                   detected_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   irq_o,
    input  logic                   irq_clr_i,
    output logic                   busy_o
);

    localparam int LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] thresh;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    logic [LEN_W-1:0] len_clamp;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] hist_nxt;
    logic [LEN_W-1:0] fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             shift_en;
    logic             hit;
    logic             cnt_inc;
    logic             irq_set;

    always_comb begin
        len_clamp = cfg_len_i;
        if (cfg_len_i == '0)
            len_clamp = LEN_W'(1);
        else if (cfg_len_i > LEN_W'(PAT_W))
            len_clamp = LEN_W'(PAT_W);
    end

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (LEN_W'(i) < len);
    end

    always_comb begin
        shift_en = (state == ARMED) && in_valid_i && !stop_i && !start_i;
        hist_nxt = (hist << 1) | PAT_W'(in_i);
        fill_nxt = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
        hit      = shift_en && (fill_nxt >= len) && (((hist_nxt ^ pattern) & mask) == '0);
        cnt_nxt  = count_o + CNT_W'(1);
        cnt_inc  = hit && (count_o != '1);
        // Only a real count change can raise irq, so a saturated count never re-fires it.
        irq_set  = cnt_inc && (thresh != '0) && (cnt_nxt == thresh);
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state       <= IDLE;
            pattern     <= DEF_PATTERN;
            len         <= LEN_W'(PAT_W);
            thresh      <= '0;
            hist        <= '0;
            fill        <= '0;
            detected_o  <= 1'b0;
            count_o     <= '0;
            irq_o       <= 1'b0;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
        end else begin
            detected_o <= 1'b0;

            if (irq_set)
                irq_o <= 1'b1;
            else if (irq_clr_i)
                irq_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        pattern <= cfg_pattern_i;
                        len     <= len_clamp;
                        thresh  <= cfg_thresh_i;
                    end
                    if (start_i && !stop_i) begin
                        state       <= ARMED;
                        hist        <= '0;
                        fill        <= '0;
                        count_o     <= '0;
                        busy_o      <= 1'b1;
                        cfg_ready_o <= 1'b0;
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        cfg_ready_o <= 1'b1;
                    end else if (start_i) begin
                        hist    <= '0;
                        fill    <= '0;
                        count_o <= '0;
                    end else if (in_valid_i) begin
                        hist       <= hist_nxt;
                        fill       <= fill_nxt;
                        detected_o <= hit;
                        if (cnt_inc)
                            count_o <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: expected detections are queued by the
// driver and checked by an independent monitor on every detected_o pulse.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   reset_i;
    logic                   cfg_valid_i;
    logic                   cfg_ready_o;
    logic [PAT_W-1:0]       cfg_pattern_i;
    logic [$clog2(PAT_W):0] cfg_len_i;
    logic [CNT_W-1:0]       cfg_thresh_i;
    logic                   start_i;
    logic                   stop_i;
    logic                   in_valid_i;
    logic                   in_i;
    logic                   detected_o;
    logic [CNT_W-1:0]       count_o;
    logic                   irq_o;
    logic                   irq_clr_i;
    logic                   busy_o;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .DEF_PATTERN(4'b1011)) dut (
        .clk(clk), .reset_i(reset_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_pattern_i(cfg_pattern_i), .cfg_len_i(cfg_len_i), .cfg_thresh_i(cfg_thresh_i),
        .start_i(start_i), .stop_i(stop_i),
        .in_valid_i(in_valid_i), .in_i(in_i),
        .detected_o(detected_o), .count_o(count_o), .irq_o(irq_o),
        .irq_clr_i(irq_clr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   cnt;
        logic irq;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_i && detected_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d count %0d, expected none",
                         cyc, count_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.cnt != int'(count_o) || e.irq != irq_o) begin
                    failures++;
                    $display("FAIL pulse: got cyc=%0d count=%0d irq=%0d expected cyc=%0d count=%0d irq=%0d",
                             cyc, count_o, irq_o, e.cyc, e.cnt, e.irq);
                end
            end
        end
    end

    task automatic clear_inputs();
        cfg_valid_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        in_valid_i = 1'b0; in_i = 1'b0; irq_clr_i = 1'b0;
    endtask

    task automatic ctl(input logic st, input logic sp, input logic clr);
        @(negedge clk);
        clear_inputs();
        start_i = st; stop_i = sp; irq_clr_i = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) ctl(1'b0, 1'b0, 1'b0);
    endtask

    task automatic bit_in(input logic v, input logic b, input logic hit, input int c,
                          input logic irq, input logic clr);
        @(negedge clk);
        clear_inputs();
        in_valid_i = v; in_i = b; irq_clr_i = clr;
        if (hit) exp_q.push_back('{cyc + 1, c, irq});
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input int l, input int t, input logic st);
        @(negedge clk);
        clear_inputs();
        cfg_valid_i = 1'b1; cfg_pattern_i = p;
        cfg_len_i = ($clog2(PAT_W)+1)'(l); cfg_thresh_i = CNT_W'(t);
        start_i = st;
    endtask

    task automatic drain(input string name);
        idle(2);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [6:0] s2;
        clear_inputs();
        cfg_pattern_i = '0; cfg_len_i = '0; cfg_thresh_i = '0;
        reset_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_detected", detected_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cfg_ready", cfg_ready_o, 1);
        reset_i = 1'b1;

        // 1: default pattern 1011
        ctl(1'b1, 1'b0, 1'b0);
        bit_in(1, 1, 0, 0, 0, 0);
        chk("armed_busy", busy_o, 1);
        chk("armed_cfg_ready", cfg_ready_o, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 1, 1, 0, 0);
        drain("t1_drain");
        chk("t1_count", count_o, 1);
        chk("t1_irq", irq_o, 0);

        // 2: re-arm, overlapping stream 1,0,1,1,0,1,1
        ctl(1'b1, 1'b0, 1'b0);
        idle(1);
        chk("t2_rearm_count", count_o, 0);
        s2 = 7'b1011011;
        for (int i = 0; i < 7; i++)
            bit_in(1, s2[6-i], (i == 3) || (i == 6), (i == 3) ? 1 : 2, 0, 0);
        drain("t2_drain");
        chk("t2_count", count_o, 2);

        // 3: gap of 3 idle cycles between bits 2 and 3
        ctl(1'b1, 1'b0, 1'b0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        idle(3);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 1, 1, 0, 0);
        drain("t3_drain");
        chk("t3_count", count_o, 1);

        // 4: pattern 110, len 3, thresh 2; clear coinciding with set loses
        ctl(1'b0, 1'b1, 1'b0);
        cfg(4'b0110, 3, 2, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 0, 1, 1, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 0, 1, 2, 1, 1);
        drain("t4_drain");
        chk("t4_count", count_o, 2);
        chk("t4_irq_set", irq_o, 1);
        ctl(1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t4_irq_clr", irq_o, 0);

        // 5: config while armed is ignored; 00/len2 would hit on 0,0
        cfg(4'b0000, 2, 5, 1'b0);
        #1 chk("t5_ready_armed", cfg_ready_o, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        ctl(1'b0, 1'b1, 1'b0);
        idle(1);
        chk("t5_stop_busy", busy_o, 0);
        chk("t5_stop_ready", cfg_ready_o, 1);
        chk("t5_count_hold", count_o, 2);
        // config + start together, len 0 clamps to 1
        cfg(4'b0001, 0, 1, 1'b1);
        bit_in(1, 1, 1, 1, 1, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        drain("t5_drain");

        // saturation with len 7 clamped to 4, thresh 255
        ctl(1'b0, 1'b1, 1'b1);
        cfg(4'b1111, 7, 255, 1'b0);
        ctl(1'b1, 1'b0, 1'b0);
        chk("sat_irq_cleared", irq_o, 0);
        for (int k = 1; k <= 261; k++)
            bit_in(1, 1, k >= 4, (k - 3 > 255) ? 255 : k - 3, (k - 3) >= 255, 0);
        ctl(1'b0, 1'b0, 1'b1);
        idle(1);
        chk("sat_irq_clr", irq_o, 0);
        bit_in(1, 1, 1, 255, 0, 0);
        bit_in(1, 1, 1, 255, 0, 0);
        drain("sat_drain");
        chk("sat_count", count_o, 255);
        chk("sat_no_reset_irq", irq_o, 0);

        // 6: asynchronous reset mid-pattern
        bit_in(1, 1, 0, 0, 0, 0);
        #3 reset_i = 1'b0;
        #1;
        chk("arst_detected", detected_o, 0);
        chk("arst_count", count_o, 0);
        chk("arst_irq", irq_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ready", cfg_ready_o, 1);
        @(negedge clk);
        clear_inputs();
        #2 reset_i = 1'b1;
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        drain("t6_idle_drain");
        chk("t6_idle_count", count_o, 0);
        chk("t6_idle_busy", busy_o, 0);
        // defaults restored: 1011, len 4, no irq
        ctl(1'b1, 1'b0, 1'b0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 0, 0, 0, 0, 0);
        bit_in(1, 1, 0, 0, 0, 0);
        bit_in(1, 1, 1, 1, 0, 0);
        drain("t6_default_drain");
        chk("t6_default_irq", irq_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
